// File: rtl/issue_select.sv
// ============================================================================
// issue_select : RS issue stage with per-FU select and issue registers.
// Optional build macro ISSUE_PERF_EN adds grant/stall performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

package issue_select_pkg;
  localparam int c_B_MASK_W = 4;
  localparam int c_SQ_W     = 8;

  localparam logic [2:0] c_FU_ALU   = 3'd0;
  localparam logic [2:0] c_FU_BR    = 3'd1;
  localparam logic [2:0] c_FU_MULT  = 3'd2;
  localparam logic [2:0] c_FU_LOAD  = 3'd3;
  localparam logic [2:0] c_FU_STORE = 3'd4;

  typedef struct packed {
    logic [2:0]            fu_type;
    logic                  Source1_ready;
    logic                  Source2_ready;
    logic [c_B_MASK_W-1:0] b_mask;
    logic [c_SQ_W-1:0]     sq_mask;
    logic [7:0]            tag;
  } RS_PACKET;
endpackage

module issue_select
  import issue_select_pkg::*;
#(
  parameter int RS_SZ    = 16,
  parameter int NUM_ALU  = 2,
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  RS_PACKET              rs_data_next [RS_SZ],
  input  logic [RS_SZ-1:0]      rs_valid_issue,
  output logic [RS_SZ-1:0]      rs_data_issuing,
  input  logic [c_B_MASK_W-1:0] b_mm_resolve,
  input  logic                  b_mm_mispred,
  output RS_PACKET              alu_packet [NUM_ALU],
  output logic [NUM_ALU-1:0]    alu_valid,
  output RS_PACKET              mult_packet,
  output logic                  mult_valid,
  output RS_PACKET              mem_packet,
  output logic                  mem_valid,
  input  logic                  mem_ready
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_mem_stall
`endif
);

  localparam logic [CNT_W-1:0] c_MULT_RELOAD = CNT_W'(MULT_LAT - 1);

  logic [RS_SZ-1:0] w_alu_rdy;
  logic [RS_SZ-1:0] w_mult_rdy;
  logic [RS_SZ-1:0] w_mem_rdy;
  logic [RS_SZ-1:0] w_alu_gnt [NUM_ALU];
  logic [RS_SZ-1:0] w_mult_gnt;
  logic [RS_SZ-1:0] w_mem_gnt;
  logic [RS_SZ-1:0] w_issuing;
  logic             w_mem_free;
  logic             w_mem_kill;
  RS_PACKET         w_alu_sel [NUM_ALU];
  RS_PACKET         w_mult_sel;
  RS_PACKET         w_mem_sel;

  RS_PACKET         r_alu_packet [NUM_ALU];
  logic [NUM_ALU-1:0] r_alu_valid;
  RS_PACKET         r_mult_packet;
  logic             r_mult_valid;
  RS_PACKET         r_mem_packet;
  logic             r_mem_valid;
  logic [CNT_W-1:0] r_mult_cnt;

  function automatic logic [RS_SZ-1:0] f_lowest(input logic [RS_SZ-1:0] v);
    return v & (~v + RS_SZ'(1));
  endfunction

  function automatic RS_PACKET f_capture(input RS_PACKET p,
                                         input logic [c_B_MASK_W-1:0] res);
    RS_PACKET q;
    q        = p;
    q.b_mask = p.b_mask & ~res;
    return q;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SZ; i++) begin
      w_alu_rdy[i]  = rs_valid_issue[i] & rs_data_next[i].Source1_ready &
                      rs_data_next[i].Source2_ready &
                      ((rs_data_next[i].fu_type == c_FU_ALU) ||
                       (rs_data_next[i].fu_type == c_FU_BR));
      w_mult_rdy[i] = rs_valid_issue[i] & rs_data_next[i].Source1_ready &
                      rs_data_next[i].Source2_ready &
                      (rs_data_next[i].fu_type == c_FU_MULT);
      // Loads wait until every older store address is known
      w_mem_rdy[i]  = rs_valid_issue[i] & rs_data_next[i].Source1_ready &
                      rs_data_next[i].Source2_ready &
                      (((rs_data_next[i].fu_type == c_FU_LOAD) &&
                        (rs_data_next[i].sq_mask == '0)) ||
                       (rs_data_next[i].fu_type == c_FU_STORE));
    end
  end

  always_comb begin
    logic [RS_SZ-1:0] v_left;
    v_left = w_alu_rdy;
    for (int k = 0; k < NUM_ALU; k++) begin
      w_alu_gnt[k] = f_lowest(v_left);
      v_left       = v_left & ~w_alu_gnt[k];
    end
  end

  assign w_mem_free = !r_mem_valid || mem_ready;
  assign w_mult_gnt = (r_mult_cnt == '0) ? f_lowest(w_mult_rdy) : '0;
  assign w_mem_gnt  = w_mem_free ? f_lowest(w_mem_rdy) : '0;

  always_comb begin
    w_issuing = w_mult_gnt | w_mem_gnt;
    for (int k = 0; k < NUM_ALU; k++) begin
      w_issuing = w_issuing | w_alu_gnt[k];
    end
  end

  assign rs_data_issuing = reset ? w_issuing : '0;

  always_comb begin
    for (int k = 0; k < NUM_ALU; k++) begin
      w_alu_sel[k] = '0;
    end
    w_mult_sel = '0;
    w_mem_sel  = '0;
    for (int i = 0; i < RS_SZ; i++) begin
      for (int k = 0; k < NUM_ALU; k++) begin
        if (w_alu_gnt[k][i]) w_alu_sel[k] = rs_data_next[i];
      end
      if (w_mult_gnt[i]) w_mult_sel = rs_data_next[i];
      if (w_mem_gnt[i])  w_mem_sel  = rs_data_next[i];
    end
  end

  assign w_mem_kill = b_mm_mispred & |(r_mem_packet.b_mask & b_mm_resolve);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_ALU; k++) begin
        r_alu_packet[k] <= '0;
      end
      r_alu_valid   <= '0;
      r_mult_packet <= '0;
      r_mult_valid  <= 1'b0;
      r_mem_packet  <= '0;
      r_mem_valid   <= 1'b0;
      r_mult_cnt    <= '0;
    end else begin
      for (int k = 0; k < NUM_ALU; k++) begin
        r_alu_valid[k]  <= |w_alu_gnt[k];
        r_alu_packet[k] <= f_capture(w_alu_sel[k], b_mm_resolve);
      end
      r_mult_valid  <= |w_mult_gnt;
      r_mult_packet <= f_capture(w_mult_sel, b_mm_resolve);

      // Unpipelined multiplier: a squashed op still drains the counter
      if (|w_mult_gnt) begin
        r_mult_cnt <= c_MULT_RELOAD;
      end else if (r_mult_cnt != '0) begin
        r_mult_cnt <= r_mult_cnt - CNT_W'(1);
      end

      if (|w_mem_gnt) begin
        r_mem_valid  <= 1'b1;
        r_mem_packet <= f_capture(w_mem_sel, b_mm_resolve);
      end else if (r_mem_valid && !mem_ready) begin
        if (w_mem_kill) begin
          r_mem_valid  <= 1'b0;
          r_mem_packet <= '0;
        end else begin
          r_mem_packet.b_mask <= r_mem_packet.b_mask & ~b_mm_resolve;
        end
      end else begin
        r_mem_valid  <= 1'b0;
        r_mem_packet <= '0;
      end
    end
  end

  // Single-cycle slots are killed in the cycle their branch mispredicts
  generate
    for (genvar k = 0; k < NUM_ALU; k++) begin : g_alu_out
      assign alu_valid[k] = r_alu_valid[k] &
                            ~(b_mm_mispred & |(r_alu_packet[k].b_mask & b_mm_resolve));
    end
  endgenerate

  assign alu_packet  = r_alu_packet;
  assign mult_packet = r_mult_packet;
  assign mult_valid  = r_mult_valid &
                       ~(b_mm_mispred & |(r_mult_packet.b_mask & b_mm_resolve));
  assign mem_packet  = r_mem_packet;
  assign mem_valid   = r_mem_valid;

`ifdef ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_mem_stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_issued    <= '0;
      r_perf_mem_stall <= '0;
    end else begin
      r_perf_issued <= r_perf_issued + 32'($countones(w_issuing));
      if (r_mem_valid && !mem_ready) begin
        r_perf_mem_stall <= r_perf_mem_stall + 32'd1;
      end
    end
  end

  assign perf_issued    = r_perf_issued;
  assign perf_mem_stall = r_perf_mem_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_select.sv
// ============================================================================
// tb_issue_select : directed self-checking bench for issue_select.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_issue_select;
  import issue_select_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  RS_PACKET    rs_data [16];
  logic [15:0] rs_valid;
  logic [15:0] issuing;
  logic [3:0]  resolve;
  logic        mispred;
  RS_PACKET    alu_pkt [2];
  logic [1:0]  alu_v;
  RS_PACKET    mult_pkt;
  logic        mult_v;
  RS_PACKET    mem_pkt;
  logic        mem_v;
  logic        mem_rdy;
`ifdef ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_mem_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  issue_select dut (
    .clock           (clock),
    .reset           (reset),
    .rs_data_next    (rs_data),
    .rs_valid_issue  (rs_valid),
    .rs_data_issuing (issuing),
    .b_mm_resolve    (resolve),
    .b_mm_mispred    (mispred),
    .alu_packet      (alu_pkt),
    .alu_valid       (alu_v),
    .mult_packet     (mult_pkt),
    .mult_valid      (mult_v),
    .mem_packet      (mem_pkt),
    .mem_valid       (mem_v),
    .mem_ready       (mem_rdy)
`ifdef ISSUE_PERF_EN
    ,
    .perf_issued     (perf_issued),
    .perf_mem_stall  (perf_mem_stall)
`endif
  );

  function automatic RS_PACKET mk(input logic [2:0] fu, input logic [3:0] bm,
                                  input logic [7:0] sq, input logic [7:0] tg);
    RS_PACKET p;
    p.fu_type       = fu;
    p.Source1_ready = 1'b1;
    p.Source2_ready = 1'b1;
    p.b_mask        = bm;
    p.sq_mask       = sq;
    p.tag           = tg;
    return p;
  endfunction

  task automatic clr();
    for (int i = 0; i < 16; i++) rs_data[i] = '0;
    rs_valid = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_rdy = 1'b0; resolve = '0; mispred = 1'b0;
    clr();
    #1 reset = 1'b0;
    rs_data[0] = mk(c_FU_ALU, 4'h0, 8'h00, 8'h01);
    rs_valid   = 16'h0001;
    #2;
    chk("rst_issuing", 32'(issuing), 32'h0);
    chk("rst_alu_v", 32'(alu_v), 32'h0);
    chk("rst_mult_v", 32'(mult_v), 32'h0);
    chk("rst_mem_v", 32'(mem_v), 32'h0);
    chk("rst_mem_pkt", 32'(mem_pkt), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    clr();
    step();

    // ALU priority: 3,5,9 ready; entry 1 has a source outstanding
    rs_data[1] = mk(c_FU_ALU, 4'h0, 8'h00, 8'd1);
    rs_data[1].Source2_ready = 1'b0;
    rs_data[3] = mk(c_FU_ALU, 4'h0, 8'h00, 8'd3);
    rs_data[5] = mk(c_FU_ALU, 4'h0, 8'h00, 8'd5);
    rs_data[9] = mk(c_FU_BR,  4'h0, 8'h00, 8'd9);
    rs_valid   = 16'h022A;
    settle();
    chk("alu_pri_issuing", 32'(issuing), 32'h0028);
    step();
    chk("alu_pri_valid", 32'(alu_v), 32'h3);
    chk("alu_pri_slot0", 32'(alu_pkt[0].tag), 32'd3);
    chk("alu_pri_slot1", 32'(alu_pkt[1].tag), 32'd5);
    rs_valid = 16'h0202;
    settle();
    chk("alu_second_issuing", 32'(issuing), 32'h0200);
    step();
    chk("alu_second_valid", 32'(alu_v), 32'h1);
    chk("alu_second_slot0", 32'(alu_pkt[0].tag), 32'd9);
    clr();
    step();
    chk("alu_drop", 32'(alu_v), 32'h0);

    // Multiplier issue spacing
    rs_data[0] = mk(c_FU_MULT, 4'h0, 8'h00, 8'd0);
    rs_data[1] = mk(c_FU_MULT, 4'h0, 8'h00, 8'd1);
    rs_valid   = 16'h0003;
    settle();
    chk("mult_first_issuing", 32'(issuing), 32'h0001);
    step();
    chk("mult_first_valid", 32'(mult_v), 32'h1);
    chk("mult_first_tag", 32'(mult_pkt.tag), 32'd0);
    rs_valid = 16'h0002;
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk("mult_busy_issuing", 32'(issuing), 32'h0);
      step();
      chk("mult_busy_valid", 32'(mult_v), 32'h0);
    end
    settle();
    chk("mult_second_issuing", 32'(issuing), 32'h0002);
    step();
    chk("mult_second_valid", 32'(mult_v), 32'h1);
    chk("mult_second_tag", 32'(mult_pkt.tag), 32'd1);
    clr();
    step();
    chk("mult_drop", 32'(mult_v), 32'h0);

    // Load blocked by an unresolved older store
    rs_data[2] = mk(c_FU_LOAD, 4'h0, 8'h04, 8'd2);
    rs_valid   = 16'h0004;
    mem_rdy    = 1'b1;
    settle();
    chk("ld_sq_block", 32'(issuing), 32'h0);
    step();
    chk("ld_sq_block_valid", 32'(mem_v), 32'h0);
    rs_data[2].sq_mask = 8'h00;
    #1;
    chk("ld_sq_clear", 32'(issuing), 32'h0004);
    step();
    chk("ld_valid", 32'(mem_v), 32'h1);
    chk("ld_tag", 32'(mem_pkt.tag), 32'd2);
    clr();
    step();
    chk("ld_accepted", 32'(mem_v), 32'h0);

    // MEM stall, squash and resolve
    mem_rdy    = 1'b0;
    rs_data[4] = mk(c_FU_LOAD, 4'b0010, 8'h00, 8'd4);
    rs_valid   = 16'h0010;
    settle();
    chk("mem_issue", 32'(issuing), 32'h0010);
    step();
    chk("mem_held_valid", 32'(mem_v), 32'h1);
    chk("mem_held_bmask", 32'(mem_pkt.b_mask), 32'h2);
    clr();
    rs_data[6] = mk(c_FU_STORE, 4'b0100, 8'h00, 8'd6);
    rs_valid   = 16'h0040;
    resolve    = 4'b0010;
    mispred    = 1'b1;
    settle();
    chk("mem_busy_no_grant", 32'(issuing), 32'h0);
    step();
    chk("mem_squashed", 32'(mem_v), 32'h0);
    resolve = '0; mispred = 1'b0;
    settle();
    chk("mem_refill_issuing", 32'(issuing), 32'h0040);
    step();
    chk("mem_refill_tag", 32'(mem_pkt.tag), 32'd6);
    clr();
    resolve = 4'b0100;
    step();
    chk("mem_resolve_valid", 32'(mem_v), 32'h1);
    chk("mem_resolve_bmask", 32'(mem_pkt.b_mask), 32'h0);
    mispred = 1'b1;
    step();
    chk("mem_cleared_survives", 32'(mem_v), 32'h1);
    resolve = '0; mispred = 1'b0; mem_rdy = 1'b1;
    step();
    chk("mem_release", 32'(mem_v), 32'h0);

    // ALU slot killed by a mispredict during its valid cycle
    rs_data[7] = mk(c_FU_ALU, 4'b1000, 8'h00, 8'd7);
    rs_valid   = 16'h0080;
    step();
    chk("alu_kill_pre", 32'(alu_v), 32'h1);
    clr();
    resolve = 4'b1000; mispred = 1'b1;
    #1;
    chk("alu_kill", 32'(alu_v), 32'h0);
    resolve = '0; mispred = 1'b0;
    #1;
    chk("alu_kill_released", 32'(alu_v), 32'h1);
    step();

    // Asynchronous reset mid-operation
    mem_rdy    = 1'b0;
    rs_data[0] = mk(c_FU_MULT, 4'h0, 8'h00, 8'h10);
    rs_data[1] = mk(c_FU_LOAD, 4'h0, 8'h00, 8'h11);
    rs_valid   = 16'h0003;
    settle();
    chk("ar_issue", 32'(issuing), 32'h0003);
    step();
    clr();
    step();
    chk("ar_mem_held", 32'(mem_v), 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("ar_mem_v", 32'(mem_v), 32'h0);
    chk("ar_mult_v", 32'(mult_v), 32'h0);
    chk("ar_alu_v", 32'(alu_v), 32'h0);
    chk("ar_mem_pkt", 32'(mem_pkt), 32'h0);
    rs_data[3] = mk(c_FU_MULT, 4'h0, 8'h00, 8'h13);
    rs_valid   = 16'h0008;
    #1;
    chk("ar_issuing_in_reset", 32'(issuing), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("ar_mult_ready_after", 32'(issuing), 32'h0008);
    step();
    chk("ar_mult_valid", 32'(mult_v), 32'h1);
    chk("ar_mult_tag", 32'(mult_pkt.tag), 32'h13);

    // Long MEM stall alongside a few ALU issues
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    clr();
    mem_rdy    = 1'b0;
    rs_data[0] = mk(c_FU_LOAD, 4'h0, 8'h00, 8'h20);
    rs_valid   = 16'h0001;
    step();
    for (int c = 1; c <= 10; c++) begin
      clr();
      if (c <= 3) begin
        rs_data[5] = mk(c_FU_ALU, 4'h0, 8'h00, 8'h25);
        rs_valid   = 16'h0020;
      end
      step();
    end
    chk("stall_mem_held", 32'(mem_v), 32'h1);
    chk("stall_alu_idle", 32'(alu_v), 32'h0);
`ifdef ISSUE_PERF_EN
    chk("perf_mem_stall", perf_mem_stall, 32'd10);
    chk("perf_issued", perf_issued, 32'd4);
`endif
    mem_rdy = 1'b1;
    step();
    chk("stall_release", 32'(mem_v), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/issue_select.md
Name: issue_select

Overview:
- Issue stage directly downstream of the reservation station.
- Each cycle it reads the RS's post-CAM/post-squash entry view, picks ready entries per functional-unit class, and returns the one-hot `rs_data_issuing` vector to the RS.
- Selected packets are latched into per-FU issue registers that drive the ALU, multiplier and memory pipelines.
- It also tracks multiplier occupancy and keeps held packets current with branch resolve/squash.

Parameters:
- RS_SZ, 16, number of RS entries.
- NUM_ALU, 2, single-cycle ALU/branch issue slots.
- MULT_LAT, 4, multiplier occupancy in cycles (unpipelined, ≥1).
- CNT_W, 3, width of the multiplier busy counter (≥ clog2(MULT_LAT)).

Ports:
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `rs_data_next`  input  RS_PACKET[RS_SZ]  RS entries this cycle (CAM/squash applied); uses fu_type, Source1_ready, Source2_ready, b_mask, sq_mask.
- `rs_valid_issue`  input  RS_SZ  entry valid, excluding entries dispatched this cycle.
- `rs_data_issuing`  output  RS_SZ  one-hot-per-slot vector of entries issued this cycle.
- `b_mm_resolve`  input  B_MASK_MASK  resolving branch bit.
- `b_mm_mispred`  input  1  mispredict qualifier for b_mm_resolve.
- `alu_packet`  output  RS_PACKET[NUM_ALU]  ALU issue registers.
- `alu_valid`  output  NUM_ALU  ALU register valid; the ALU always accepts.
- `mult_packet`  output  RS_PACKET  multiplier issue register.
- `mult_valid`  output  1  one-cycle start pulse to the multiplier.
- `mem_packet`  output  RS_PACKET  load/store issue register.
- `mem_valid`  output  1  memory register valid.
- `mem_ready`  input  1  memory unit accepts `mem_packet` this cycle.

Behaviour:
- Readiness: `ready[i] = rs_valid_issue[i] & Source1_ready & Source2_ready`; loads additionally require `sq_mask == 0`. Entries whose b_mask hits a mispredicting `b_mm_resolve` are already cleared by the RS and never appear valid.
- Selection (combinational, lowest index wins):
  - ALU: up to NUM_ALU ready ALU/branch entries.
  - MULT: one entry, only when `mult_cnt == 0`.
  - MEM: one load/store entry, only when the MEM slot is free, i.e. `!mem_valid || mem_ready`.
  - `rs_data_issuing` = OR of all grants; never more than one grant per entry.
- Latency: an entry selected in cycle t appears on the `*_packet`/`*_valid` outputs from edge t+1.
- Captured packets get `b_mask &= ~b_mm_resolve` applied at capture.
- ALU and MULT registers hold for exactly one cycle; they are cleared next cycle unless reloaded.
- MEM register: holds while `mem_valid && !mem_ready`. While held, each cycle it:
  - clears its b_mask bit on resolve;
  - invalidates (`mem_valid` → 0) on mispredict with `b_mask & b_mm_resolve != 0`.
- ALU/MULT registers are also invalidated on the same mispredict condition in their valid cycle.
- Squash has priority over hold. A new MEM grant in the same cycle as a squash of the held packet is allowed only if `mem_ready` was 1.
- Multiplier counter:
  - On a mult issue edge, `mult_cnt` loads MULT_LAT-1.
  - Otherwise it decrements if non-zero.
  - Issue spacing is therefore exactly MULT_LAT cycles.
  - A squash of an issued mult does not clear `mult_cnt`; the unit drains.
- Reset (asynchronous, any time): all `*_valid` = 0, all `*_packet` = 0, `mult_cnt` = 0. `rs_data_issuing` = 0 while reset is asserted.
- Empty RS (`rs_valid_issue` all zero): no grants, all valids drop after one cycle, except a stalled MEM packet, which holds.

Optional Feature:
- Macro `ISSUE_PERF_EN`. When defined, the block adds:
  - output `perf_issued` (32 bits): count of grants per cycle (popcount of `rs_data_issuing`), accumulated.
  - output `perf_mem_stall` (32 bits): counts cycles with `mem_valid && !mem_ready`.
- Both counters wrap on overflow and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- ALU priority: entries 3, 5, 9 valid ALU with sources ready, NUM_ALU=2 -> `rs_data_issuing` = 0x0028 in cycle t; next cycle `alu_valid` = 2'b11 holding entries 3 and 5. Entry 9 issues in cycle t+1 (RS has cleared 3 and 5).
- Mult spacing: mults ready at entries 0 and 1, MULT_LAT=4 -> entry 0 issues at cycle t, entry 1 at cycle t+4; `mult_valid` high only in cycles t+1 and t+5.
- Load blocked by SQ: load at entry 2 with `sq_mask` = 8'h04, sources ready -> not issued. Once `sq_mask` becomes 0 it issues the same cycle.
- MEM stall and squash: `mem_packet` held with `mem_ready`=0 and b_mask 4'b0010; `b_mm_resolve` = 4'b0010 with `b_mm_mispred` = 1 -> `mem_valid` = 0 next cycle. With `b_mm_mispred` = 0 instead -> still valid with b_mask 4'b0000.
- Async reset mid-op: assert `reset`=0 between clock edges while `mult_cnt` = 2 and `mem_valid` = 1 -> all valids and `mult_cnt` are 0 immediately. After release, a ready mult issues on the first cycle.
- `ISSUE_PERF_EN`: 10 cycles of stalled MEM plus 3 issued ALU ops -> `perf_mem_stall` = 10, `perf_issued` = 4 (3 ALU + the stalled load).
